rx_axis_adapter: RTL and testbench
==================================

Name: rx_axis_adapter

Overview:
- Bridges the MAC receive byte interface (no backpressure) to an AXI-Stream master (tdata/tvalid/tready/tlast) in the clk_mac domain.
- Buffers each frame in an internal store-and-forward byte FIFO and releases it downstream only after a good end of frame.
- Discards errored, overflowed, aborted and empty frames completely, so downstream sees only whole good frames.
- Sits between the MAC receive path and the receive packet logic; it is the counterpart of the transmit AXIS adapter.

Parameters:
- ADDR_W, 11, log2 of FIFO depth in bytes; 2048 holds one max-size frame plus margin.
- CNT_W, 16, width of the frame statistics counters.

Ports:
- clk_mac  in  1  MAC clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_vld  in  1  beat valid.
- rx_dat  in  8  data byte; ignored on eof beats.
- rx_sof  in  1  qualifies the first data byte of a frame.
- rx_eof  in  1  end-of-frame marker beat; carries no data.
- rx_err  in  1  frame bad (FCS or PHY error); sampled only on the eof beat.
- rx_axis_mac_tdata  out  8  stream byte.
- rx_axis_mac_tvalid  out  1  stream valid.
- rx_axis_mac_tlast  out  1  last byte of frame.
- rx_axis_mac_tready  in  1  downstream ready.
- rx_frames_good  out  CNT_W  saturating count of committed frames.
- rx_frames_dropped  out  CNT_W  saturating count of discarded frames.

Behaviour:
- Reset (rst=1 at an edge):
  - wr/commit/rd pointers, holding register, state and counters clear.
  - tvalid=0 and tlast=0 from the next cycle; tdata=0.
  - All partial and committed data is lost. Reset mid-frame or mid-readout has no other effect.
- Input beats are sampled only when rx_vld=1.
- Data beat: rx_eof=0. Eof beat: rx_eof=1; rx_sof is ignored on it.
- FIFO entries are 9 bits: {last, byte}.
- Pointers are ADDR_W+1 bits:
  - used = wr_ptr - rd_ptr.
  - full when used == 2^ADDR_W.
- Write FSM states: IDLE, FIRST, DATA, DISCARD.
  - IDLE:
    - sof data beat: load byte into the holding register, go FIRST.
    - Data beat without sof: ignored.
    - Eof beat: ignored, not counted.
  - FIRST/DATA:
    - Data beat without sof: write held byte with last=0, wr_ptr+1, load new byte, go DATA.
    - If full at that write: roll back wr_ptr to commit_ptr and go DISCARD.
  - FIRST/DATA, eof beat:
    - rx_err=0 and not full: write held byte with last=1, commit_ptr <= wr_ptr+1, rx_frames_good+1, go IDLE.
    - rx_err=1 or full: roll back wr_ptr to commit_ptr, rx_frames_dropped+1, go IDLE.
  - FIRST/DATA, sof data beat (abort without eof):
    - Roll back, rx_frames_dropped+1.
    - The new byte starts a fresh frame: load it into the holding register, go FIRST.
  - DISCARD:
    - Ignore data beats.
    - Eof beat: rx_frames_dropped+1, go IDLE.
    - sof data beat: rx_frames_dropped+1, load byte, go FIRST.
- Empty frames cannot be committed, because a frame needs at least one sof data byte.
- Read side:
  - Reads only entries below commit_ptr; rollback never affects it.
  - Block-RAM read with 1-cycle latency, followed by an output register and a skid register.
  - Result: full throughput (1 byte/cycle with tready=1), no combinational path from tready to FIFO read.
- AXIS rules:
  - tdata, tlast and tvalid are held stable while tvalid=1 and tready=0.
  - A transfer happens when tvalid=1 and tready=1.
  - tlast=1 exactly on the final byte of each frame.
- Latency: for an eof beat sampled at edge N into an empty FIFO, the first byte is presented with tvalid=1 in cycle N+2.
- Simultaneous commit and read in one cycle are both honoured.
- used is computed from the pre-edge pointers, so a read in the same cycle does not free space for the write.
- Counters saturate at 2^CNT_W-1.

Test Plan:
- 64-byte good frame (0x00..0x3F), sof on byte 0, eof with err=0, tready=1:
  - 64 transfers 0x00..0x3F, tlast only on 0x3F.
  - First tvalid 2 cycles after the eof beat.
  - good=1, dropped=0.
- Same frame ending with eof err=1:
  - No tvalid ever.
  - dropped=1.
  - A following good 1-byte frame 0xA5 emerges with tlast=1.
- ADDR_W=4, 20-byte frame: dropped=1, no output. A following good 16-byte frame passes intact.
- Frame A (10 bytes) interrupted by sof of frame B (5 bytes 0xB0..0xB4, good eof):
  - Only 0xB0..0xB4 output.
  - dropped=1, good=1.
- Three back-to-back good frames (60/1/1500 bytes) with random tready and 30% stalls:
  - Byte-exact output in order, correct tlast positions.
  - tdata stable whenever tvalid=1 and tready=0.
- rst=1 for one cycle mid-readout of a committed frame:
  - tvalid=0 next cycle, counters 0, no residual bytes.
  - The next good frame passes normally.

Source files
------------

// File: rtl/rx_axis_adapter.sv
// Store-and-forward bridge from the MAC receive byte interface to an AXI-Stream master.
// Frames become visible to the reader only after a good end of frame; anything else is rolled back.
module rx_axis_adapter #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic             clk_mac,
    input  logic             rst,
    input  logic             rx_vld,
    input  logic [7:0]       rx_dat,
    input  logic             rx_sof,
    input  logic             rx_eof,
    input  logic             rx_err,
    output logic [7:0]       rx_axis_mac_tdata,
    output logic             rx_axis_mac_tvalid,
    output logic             rx_axis_mac_tlast,
    input  logic             rx_axis_mac_tready,
    output logic [CNT_W-1:0] rx_frames_good,
    output logic [CNT_W-1:0] rx_frames_dropped
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]  FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_DATA,
        S_DISCARD
    } state_t;

    // FIFO storage: {last, byte}
    logic [8:0]        r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   w_wr_ptr_next;
    logic [ADDR_W:0]   r_commit_ptr;
    logic [ADDR_W:0]   w_commit_ptr_next;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [7:0]        r_hold;
    logic [7:0]        w_hold_next;
    logic              w_we;
    logic [8:0]        w_wdata;
    logic              w_good_inc;
    logic              w_drop_inc;

    logic [ADDR_W:0]   w_used;
    logic              w_full;
    logic              w_data_beat;
    logic              w_sof_beat;
    logic              w_eof_beat;

    logic              w_avail;
    logic              w_rd_en;
    logic              w_ram_moves;
    logic              w_pop;
    logic [8:0]        r_ram_q;
    logic              r_ram_vld;
    logic [8:0]        r_out_q;
    logic              r_out_vld;
    logic [8:0]        r_skid_q;
    logic              r_skid_vld;

    logic [1:0]                 w_cnt_inc;
    logic [1:0][CNT_W-1:0]      w_cnt;

    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_used == FULL_CNT);
    assign w_data_beat = rx_vld & ~rx_eof;
    assign w_sof_beat  = w_data_beat & rx_sof;
    assign w_eof_beat  = rx_vld & rx_eof;

    // ------------------------------------------------------------------
    // Write side FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_mac) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_hold       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_commit_ptr <= w_commit_ptr_next;
            r_hold       <= w_hold_next;
        end
    end

    // The newest byte is kept in r_hold so that the byte preceding eof can be written with last=1.
    always_comb begin
        w_state_next      = r_state;
        w_wr_ptr_next     = r_wr_ptr;
        w_commit_ptr_next = r_commit_ptr;
        w_hold_next       = r_hold;
        w_we              = 1'b0;
        w_wdata           = {1'b0, r_hold};
        w_good_inc        = 1'b0;
        w_drop_inc        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sof_beat) begin
                    w_hold_next  = rx_dat;
                    w_state_next = S_FIRST;
                end
            end
            S_FIRST, S_DATA: begin
                if (w_eof_beat) begin
                    if (!rx_err && !w_full) begin
                        w_we              = 1'b1;
                        w_wdata           = {1'b1, r_hold};
                        w_wr_ptr_next     = r_wr_ptr + PTR_ONE;
                        w_commit_ptr_next = r_wr_ptr + PTR_ONE;
                        w_good_inc        = 1'b1;
                    end else begin
                        w_wr_ptr_next = r_commit_ptr;
                        w_drop_inc    = 1'b1;
                    end
                    w_state_next = S_IDLE;
                end else if (w_sof_beat) begin
                    w_wr_ptr_next = r_commit_ptr;
                    w_drop_inc    = 1'b1;
                    w_hold_next   = rx_dat;
                    w_state_next  = S_FIRST;
                end else if (w_data_beat) begin
                    if (w_full) begin
                        w_wr_ptr_next = r_commit_ptr;
                        w_state_next  = S_DISCARD;
                    end else begin
                        w_we          = 1'b1;
                        w_wr_ptr_next = r_wr_ptr + PTR_ONE;
                        w_hold_next   = rx_dat;
                        w_state_next  = S_DATA;
                    end
                end
            end
            S_DISCARD: begin
                if (w_eof_beat) begin
                    w_drop_inc   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_sof_beat) begin
                    w_drop_inc   = 1'b1;
                    w_hold_next  = rx_dat;
                    w_state_next = S_FIRST;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_mac) begin
        if (w_we) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read side: RAM output register -> output register -> skid register.
    // The RAM stage only advances when the skid is empty, so the read
    // enable depends on registered state alone, never on tready.
    // ------------------------------------------------------------------
    assign w_avail     = (r_commit_ptr != r_rd_ptr);
    assign w_ram_moves = r_ram_vld & ~r_skid_vld;
    assign w_rd_en     = w_avail & (~r_ram_vld | ~r_skid_vld);
    assign w_pop       = r_out_vld & rx_axis_mac_tready;

    always_ff @(posedge clk_mac) begin
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_ram_vld <= 1'b1;
            end else if (w_ram_moves) begin
                r_ram_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            r_out_q    <= '0;
            r_out_vld  <= 1'b0;
            r_skid_q   <= '0;
            r_skid_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_vld) begin
                r_out_q    <= r_skid_q;
                r_skid_vld <= 1'b0;
            end else if (w_ram_moves) begin
                r_out_q <= r_ram_q;
            end else begin
                r_out_vld <= 1'b0;
            end
        end else if (!r_out_vld) begin
            if (w_ram_moves) begin
                r_out_q   <= r_ram_q;
                r_out_vld <= 1'b1;
            end
        end else if (w_ram_moves) begin
            r_skid_q   <= r_ram_q;
            r_skid_vld <= 1'b1;
        end
    end

    assign rx_axis_mac_tdata  = r_out_q[7:0];
    assign rx_axis_mac_tvalid = r_out_vld;
    assign rx_axis_mac_tlast  = r_out_vld & r_out_q[8];

    // ------------------------------------------------------------------
    // Saturating frame counters: index 0 good, index 1 dropped
    // ------------------------------------------------------------------
    assign w_cnt_inc = {w_drop_inc, w_good_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk_mac) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc[gi] && !(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign rx_frames_good    = w_cnt[0];
    assign rx_frames_dropped = w_cnt[1];

endmodule

// File: tb/tb_rx_axis_adapter.sv
// Directed bench for rx_axis_adapter: a full-size instance and a 16-byte FIFO instance.
module tb_rx_axis_adapter;

    logic        clk_mac = 1'b0;
    logic        rst;
    logic        vld_a, vld_b;
    logic [7:0]  dat;
    logic        sof, eof, err;
    logic        tready_a, tready_b;

    logic [7:0]  tdata_a, tdata_b;
    logic        tvalid_a, tvalid_b, tlast_a, tlast_b;
    logic [15:0] good_a, drop_a, good_b, drop_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_vld = -1;
    int          eof_cyc = 0;
    bit          mon_en = 1'b1;
    bit          rand_rdy = 1'b0;
    logic [8:0]  exp_a[$];
    logic [8:0]  exp_b[$];

    always #5 clk_mac = ~clk_mac;
    always @(posedge clk_mac) cyc <= cyc + 1;

    rx_axis_adapter #(.ADDR_W(11), .CNT_W(16)) dut_a (
        .clk_mac            (clk_mac),
        .rst                (rst),
        .rx_vld             (vld_a),
        .rx_dat             (dat),
        .rx_sof             (sof),
        .rx_eof             (eof),
        .rx_err             (err),
        .rx_axis_mac_tdata  (tdata_a),
        .rx_axis_mac_tvalid (tvalid_a),
        .rx_axis_mac_tlast  (tlast_a),
        .rx_axis_mac_tready (tready_a),
        .rx_frames_good     (good_a),
        .rx_frames_dropped  (drop_a)
    );

    rx_axis_adapter #(.ADDR_W(4), .CNT_W(16)) dut_b (
        .clk_mac            (clk_mac),
        .rst                (rst),
        .rx_vld             (vld_b),
        .rx_dat             (dat),
        .rx_sof             (sof),
        .rx_eof             (eof),
        .rx_err             (err),
        .rx_axis_mac_tdata  (tdata_b),
        .rx_axis_mac_tvalid (tvalid_b),
        .rx_axis_mac_tlast  (tlast_b),
        .rx_axis_mac_tready (tready_b),
        .rx_frames_good     (good_b),
        .rx_frames_dropped  (drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // tready changes just after the rising edge; 30% stalls when randomised
    initial begin
        tready_a = 1'b1;
        tready_b = 1'b1;
        forever begin
            @(posedge clk_mac);
            #1;
            tready_a = rand_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Scoreboard and hold-stability monitor for the full-size instance
    initial begin
        logic       prev_v;
        logic       prev_r;
        logic [8:0] prev_d;
        prev_v = 1'b0;
        prev_r = 1'b1;
        prev_d = '0;
        forever begin
            @(negedge clk_mac);
            if (mon_en && !rst) begin
                if (tvalid_a && first_vld < 0) first_vld = cyc;
                if (prev_v && !prev_r) begin
                    chk("hold_valid", 32'(tvalid_a), 32'd1);
                    chk("hold_data", 32'({tlast_a, tdata_a}), 32'(prev_d));
                end
                if (tvalid_a && tready_a) begin
                    if (exp_a.size() == 0)
                        chk("spurious_a", 32'({tlast_a, tdata_a}), 32'h200);
                    else
                        chk("data_a", 32'({tlast_a, tdata_a}), 32'(exp_a.pop_front()));
                end
            end
            prev_v = tvalid_a;
            prev_r = tready_a;
            prev_d = {tlast_a, tdata_a};
        end
    end

    initial begin
        forever begin
            @(negedge clk_mac);
            if (!rst && tvalid_b && tready_b) begin
                if (exp_b.size() == 0)
                    chk("spurious_b", 32'({tlast_b, tdata_b}), 32'h200);
                else
                    chk("data_b", 32'({tlast_b, tdata_b}), 32'(exp_b.pop_front()));
            end
        end
    end

    task automatic beat(input bit sel, input bit s, input bit e, input bit r, input logic [7:0] d);
        @(negedge clk_mac);
        vld_a = !sel;
        vld_b = sel;
        sof   = s;
        eof   = e;
        err   = r;
        dat   = d;
        if (e) eof_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_mac);
            vld_a = 1'b0;
            vld_b = 1'b0;
            sof   = 1'b0;
            eof   = 1'b0;
            err   = 1'b0;
            dat   = 8'h00;
        end
    endtask

    // mode 0: good eof, 1: errored eof, 2: no eof (aborted by the next sof)
    task automatic send(input bit sel, input int n, input logic [7:0] base, input logic [7:0] step,
                        input int mode, input bit expect_out);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i) * step;
            if (expect_out) begin
                if (sel) exp_b.push_back({i == n - 1, b});
                else     exp_a.push_back({i == n - 1, b});
            end
            beat(sel, i == 0, 1'b0, 1'b0, b);
        end
        if (mode == 0) beat(sel, 1'b0, 1'b1, 1'b0, 8'h00);
        if (mode == 1) beat(sel, 1'b0, 1'b1, 1'b1, 8'h00);
        $display("frame dut=%s len=%0d base=%02h mode=%0d expect_out=%0d",
                 sel ? "b" : "a", n, base, mode, expect_out);
    endtask

    task automatic drain(input bit sel, input int max_cyc);
        int k;
        k = 0;
        while ((sel ? exp_b.size() : exp_a.size()) != 0 && k < max_cyc) begin
            @(negedge clk_mac);
            k++;
        end
        idle(2);
        chk(sel ? "drain_b" : "drain_a", 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        vld_a = 1'b0;
        vld_b = 1'b0;
        sof   = 1'b0;
        eof   = 1'b0;
        err   = 1'b0;
        dat   = 8'h00;
        repeat (3) @(negedge clk_mac);
        rst = 1'b0;

        chk("rst_tvalid", 32'(tvalid_a), 32'd0);
        chk("rst_tlast", 32'(tlast_a), 32'd0);
        chk("rst_tdata", 32'(tdata_a), 32'd0);
        chk("rst_good", 32'(good_a), 32'd0);
        chk("rst_dropped", 32'(drop_a), 32'd0);

        // 64-byte good frame
        first_vld = -1;
        send(1'b0, 64, 8'h00, 8'h01, 0, 1'b1);
        idle(1);
        drain(1'b0, 200);
        chk("latency", 32'(first_vld), 32'(eof_cyc + 2));
        chk("good_1", 32'(good_a), 32'd1);
        chk("dropped_1", 32'(drop_a), 32'd0);

        // same frame with errored eof, then a 1-byte good frame
        send(1'b0, 64, 8'h00, 8'h01, 1, 1'b0);
        idle(10);
        chk("err_tvalid", 32'(tvalid_a), 32'd0);
        chk("err_dropped", 32'(drop_a), 32'd1);
        chk("err_good", 32'(good_a), 32'd1);
        send(1'b0, 1, 8'hA5, 8'h00, 0, 1'b1);
        idle(1);
        drain(1'b0, 50);
        chk("a5_good", 32'(good_a), 32'd2);

        // overflow on a 16-byte FIFO, then an exactly-fitting frame
        send(1'b1, 20, 8'h40, 8'h01, 0, 1'b0);
        idle(5);
        chk("ovf_dropped", 32'(drop_b), 32'd1);
        chk("ovf_good", 32'(good_b), 32'd0);
        chk("ovf_tvalid", 32'(tvalid_b), 32'd0);
        send(1'b1, 16, 8'h80, 8'h01, 0, 1'b1);
        idle(1);
        drain(1'b1, 100);
        chk("fit_good", 32'(good_b), 32'd1);
        chk("fit_dropped", 32'(drop_b), 32'd1);

        // frame A aborted by the sof of frame B
        send(1'b0, 10, 8'h10, 8'h01, 2, 1'b0);
        send(1'b0, 5, 8'hB0, 8'h01, 0, 1'b1);
        idle(1);
        drain(1'b0, 50);
        chk("abort_good", 32'(good_a), 32'd3);
        chk("abort_dropped", 32'(drop_a), 32'd2);

        // back-to-back frames under random backpressure
        rand_rdy = 1'b1;
        send(1'b0, 60, 8'h03, 8'h07, 0, 1'b1);
        send(1'b0, 1, 8'h5A, 8'h00, 0, 1'b1);
        send(1'b0, 1500, 8'h00, 8'h01, 0, 1'b1);
        idle(1);
        drain(1'b0, 6000);
        rand_rdy = 1'b0;
        idle(2);
        chk("b2b_good", 32'(good_a), 32'd6);
        chk("b2b_dropped", 32'(drop_a), 32'd2);

        // reset in the middle of a readout
        send(1'b0, 64, 8'h20, 8'h01, 0, 1'b1);
        idle(1);
        k = 0;
        while (exp_a.size() > 50 && k < 200) begin
            @(negedge clk_mac);
            k++;
        end
        chk("readout_started", 32'(exp_a.size() <= 50), 32'd1);
        @(posedge clk_mac);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        exp_a.delete();
        @(posedge clk_mac);
        #2;
        rst = 1'b0;
        chk("mid_rst_tvalid", 32'(tvalid_a), 32'd0);
        chk("mid_rst_tlast", 32'(tlast_a), 32'd0);
        chk("mid_rst_tdata", 32'(tdata_a), 32'd0);
        chk("mid_rst_good", 32'(good_a), 32'd0);
        chk("mid_rst_dropped", 32'(drop_a), 32'd0);
        mon_en = 1'b1;
        idle(20);
        chk("residual_tvalid", 32'(tvalid_a), 32'd0);
        send(1'b0, 3, 8'hC0, 8'h01, 0, 1'b1);
        idle(1);
        drain(1'b0, 50);
        chk("post_rst_good", 32'(good_a), 32'd1);
        chk("post_rst_dropped", 32'(drop_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
